// File: rtl/fixmul_pkg.sv
// Shared constants and control-word type for the fixed-point multiply/MAC pipeline.
package fixmul_pkg;

  localparam int W_DEF     = 16;
  localparam int FRAC_DEF  = 15;
  localparam int GUARD_DEF = 8;
  localparam bit ROUND_DEF = 1'b1;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  typedef struct packed {
    logic mode;
    logic first;
    logic last;
  } ctl_t;

  function automatic int acc_width(input int w, input int guard);
    return 2 * w + guard;
  endfunction

endpackage

// File: rtl/fixmul_round_sat.sv
// Rounds/shifts an accumulator-width sum down to a W-bit Q result and clamps it.
// Purely combinational; no latency, no flow control.
module fixmul_round_sat #(
  parameter int W     = 16,
  parameter int FRAC  = 15,
  parameter int ACC_W = 40,
  parameter bit ROUND = 1'b1
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [W-1:0]     y,
  output logic                    sat
);

  // One extra bit so the rounding bias can never overflow the sum.
  localparam logic signed [ACC_W:0] HALF  = ROUND ? ((ACC_W+1)'(1) << (FRAC-1)) : '0;
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0] sum_ext;
  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    sum_ext = $signed({sum[ACC_W-1], sum});
    biased  = sum_ext + HALF;
    shifted = biased >>> FRAC;
    y       = shifted[W-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      y   = MAX_V[W-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      y   = MIN_V[W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/fixmul_pipe.sv
// Pipelined signed fixed-point multiply / MAC, 3-cycle latency, 1 beat per cycle.
// A stalled output (out_valid & ~out_ready) freezes every stage and the accumulator.
module fixmul_pipe
  import fixmul_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter bit ROUND = ROUND_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_mode,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_sat
);

  localparam int ACC_W = acc_width(W, GUARD);
  localparam int P_W   = 2 * W;

  logic                    en;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  ctl_t                    s1_ctl_q, s1_ctl_d;
  logic                    s2_vld_q, s2_vld_d;
  logic signed [P_W-1:0]   s2_prod_q, s2_prod_d;
  ctl_t                    s2_ctl_q, s2_ctl_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_vld_q, out_vld_d;
  logic [W-1:0]            out_y_q, out_y_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] prod_ext, acc_base, mac_sum, sum;
  logic                    emit;
  logic [W-1:0]            rs_y;
  logic                    rs_sat;

  assign en        = ~(out_vld_q & ~out_ready);
  assign in_ready  = en;
  assign out_valid = out_vld_q;
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_ctl_d  = s1_ctl_q;
    s2_vld_d  = s2_vld_q;
    s2_prod_d = s2_prod_q;
    s2_ctl_d  = s2_ctl_q;
    if (en) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d   = $signed(in_a);
        s1_b_d   = $signed(in_b);
        s1_ctl_d = '{mode: in_mode, first: in_first, last: in_last};
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_prod_d = s1_a_q * s1_b_q;
        s2_ctl_d  = s1_ctl_q;
      end
    end
  end

  always_comb begin
    prod_ext = {{GUARD{s2_prod_q[P_W-1]}}, s2_prod_q};
    acc_base = s2_ctl_q.first ? '0 : acc_q;
    mac_sum  = acc_base + prod_ext;
    sum      = (s2_ctl_q.mode == MODE_MAC) ? mac_sum : prod_ext;
    emit     = (s2_ctl_q.mode == MODE_MUL) || s2_ctl_q.last;
  end

  fixmul_round_sat #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W),
    .ROUND (ROUND)
  ) u_round_sat (
    .sum (sum),
    .y   (rs_y),
    .sat (rs_sat)
  );

  // Multiply beats pass straight through and never touch an open accumulation.
  always_comb begin
    acc_d     = acc_q;
    out_vld_d = out_vld_q;
    out_y_d   = out_y_q;
    out_sat_d = out_sat_q;
    if (en) begin
      out_vld_d = 1'b0;
      if (s2_vld_q) begin
        if (s2_ctl_q.mode == MODE_MAC) begin
          acc_d = s2_ctl_q.last ? '0 : mac_sum;
        end
        if (emit) begin
          out_vld_d = 1'b1;
          out_y_d   = rs_y;
          out_sat_d = rs_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_ctl_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_ctl_q  <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_y_q   <= '0;
      out_sat_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_ctl_q  <= s1_ctl_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      s2_ctl_q  <= s2_ctl_d;
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      out_y_q   <= out_y_d;
      out_sat_q <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fixmul_pipe.sv
// Directed bench for fixmul_pipe: Q1.15 multiply, MAC, saturation, backpressure, reset flush.
module tb_fixmul_pipe;
  import fixmul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, in_first, in_last, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_y;
  logic        r0_in_ready, r0_out_valid, r0_out_sat;
  logic [15:0] r0_out_y;

  typedef struct {
    logic [15:0] y;
    logic        sat;
    logic [15:0] y0;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fixmul_pipe #(.W(16), .FRAC(15), .GUARD(8), .ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat)
  );

  fixmul_pipe #(.W(16), .FRAC(15), .GUARD(8), .ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_y(r0_out_y), .out_sat(r0_out_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every result handshake is matched, in order, against the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {16'h0, out_y}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_y", {16'h0, out_y}, {16'h0, e.y});
        check("out_sat", {31'h0, out_sat}, {31'h0, e.sat});
        check("r0_out_valid", {31'h0, r0_out_valid}, 32'h1);
        check("r0_out_y", {16'h0, r0_out_y}, {16'h0, e.y0});
        check("r0_out_sat", {31'h0, r0_out_sat}, {31'h0, e.sat});
      end
    end
  end

  task automatic expect_res(input logic [15:0] y, input logic sat, input logic [15:0] y0);
    exp_t e;
    e.y = y; e.sat = sat; e.y0 = y0;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns at the edge on which the beat was taken.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic mode, input logic first, input logic last);
    logic rdy;
    int   k;
    #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    in_mode = mode; in_first = first; in_last = last;
    k = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      k++;
      if (k > 200) begin
        check("send_timeout", 32'h0, 32'h1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    #1 in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    #1 in_valid = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_mode = MODE_MUL; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_y", {16'h0, out_y}, 32'h0);
    check("rst_out_sat", {31'h0, out_sat}, 32'h0);
    rst = 1'b0;
    #1 check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);

    // -1 * -1 saturates; exact three-edge latency
    expect_res(16'h7FFF, 1'b1, 16'h7FFF);
    send(16'h8000, 16'h8000, MODE_MUL, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    check("lat_e1_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1 check("lat_e2_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_e3_valid", {31'h0, out_valid}, 32'h1);
    check("lat_e3_y", {16'h0, out_y}, 32'h7FFF);
    expect_res(16'h0000, 1'b0, 16'h0000);
    send(16'hFFFF, 16'h0000, MODE_MUL, 1'b0, 1'b0);
    expect_res(16'h0000, 1'b0, 16'h0000);
    send(16'h5FFF, 16'h0000, MODE_MUL, 1'b0, 1'b0);
    drain("drain_t1");

    // 0.5*0.5; smallest product rounds up or truncates; -0.99954*-0.10156
    expect_res(16'h2000, 1'b0, 16'h2000);
    send(16'h4000, 16'h4000, MODE_MUL, 1'b0, 1'b0);
    expect_res(16'h0001, 1'b0, 16'h0000);
    send(16'h0001, 16'h4000, MODE_MUL, 1'b0, 1'b0);
    expect_res(16'h0CFE, 1'b0, 16'h0CFE);
    send(16'h800F, 16'hF300, MODE_MUL, 1'b0, 1'b0);
    drain("drain_t2");

    // 3-term MAC of 0.25 each, no output before last
    send(16'h4000, 16'h4000, MODE_MAC, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b0);
    idle(4);
    #1 check("mac_no_early", {31'h0, out_valid}, 32'h0);
    expect_res(16'h6000, 1'b0, 16'h6000);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b1);
    drain("drain_mac3");

    // 4 terms reach 1.0 and clamp
    expect_res(16'h7FFF, 1'b1, 16'h7FFF);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b1);
    drain("drain_mac4");

    // Two terms of -0.99997 clamp negative
    expect_res(16'h8000, 1'b1, 16'h8000);
    send(16'h8000, 16'h7FFF, MODE_MAC, 1'b1, 1'b0);
    send(16'h8000, 16'h7FFF, MODE_MAC, 1'b0, 1'b1);
    drain("drain_negsat");

    // first&last single beat, then a mul interleaved into an open MAC
    expect_res(16'hAFF1, 1'b0, 16'hAFF1);
    send(16'h8000, 16'h500F, MODE_MAC, 1'b1, 1'b1);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b1, 1'b0);
    expect_res(16'h2000, 1'b0, 16'h2000);
    send(16'h4000, 16'h4000, MODE_MUL, 1'b0, 1'b0);
    expect_res(16'h4000, 1'b0, 16'h4000);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b1);
    drain("drain_t4");

    // Backpressure: six back-to-back beats against a 5-cycle stall
    #1 out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          logic [15:0] bv;
          logic [15:0] yv;
          bv = 16'(i << 11);
          yv = 16'(i * 1024);
          expect_res(yv, 1'b0, yv);
          send(16'h4000, bv, MODE_MUL, 1'b0, 1'b0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_r0_in_ready", {31'h0, r0_in_ready}, 32'h0);
        check("bp_hold_y", {16'h0, out_y}, 32'h0400);
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");

    // Reset mid-MAC discards the partial sum and in-flight beats
    send(16'h4000, 16'h4000, MODE_MAC, 1'b1, 1'b0);
    idle(3);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b0);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    #1 check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    expect_res(16'h2000, 1'b0, 16'h2000);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b0, 1'b1);
    drain("drain_rst_lastonly");
    expect_res(16'h2000, 1'b0, 16'h2000);
    send(16'h4000, 16'h4000, MODE_MAC, 1'b1, 1'b1);
    drain("drain_rst_single");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
